// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage, hazard, interrupt and ID/EX control signals of pipe_ctrl_unit.
// Define PIPE_CTRL_PERF_EN to add the stall_cnt/flush_cnt counter outputs.
interface pipe_ctrl_if #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_ID_W = 2
);
  logic id_valid;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic branch_taken, kernel_mode;
  logic [NUM_IRQ-1:0] irq_req;
  logic irq_mask_we;
  logic [NUM_IRQ-1:0] irq_mask_wdata;
  logic stall_if, flush_if_id;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src1, ex_alu_src2;
  logic [4:0] ex_reg_dst_addr;
  logic [1:0] ex_mem_to_reg;
  logic [3:0] ex_alu_op;
  logic [2:0] ex_branch;
  logic ex_vector, ex_cause;
  logic [IRQ_ID_W-1:0] irq_id;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  modport master (
    output id_valid, opcode, funct, rs, rt, rd, branch_taken, kernel_mode, irq_req, irq_mask_we, irq_mask_wdata,
    input stall_if, flush_if_id, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src1, ex_alu_src2,
    input ex_reg_dst_addr, ex_mem_to_reg, ex_alu_op, ex_branch, ex_vector, ex_cause, irq_id
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );
  modport slave (
    input id_valid, opcode, funct, rs, rt, rd, branch_taken, kernel_mode, irq_req, irq_mask_we, irq_mask_wdata,
    output stall_if, flush_if_id, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src1, ex_alu_src2,
    output ex_reg_dst_addr, ex_mem_to_reg, ex_alu_op, ex_branch, ex_vector, ex_cause, irq_id
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: registered ID/EX decode with load-use stall, branch/jump flush and interrupt/exception entry.
// Define PIPE_CTRL_PERF_EN to add stall_cnt/flush_cnt cycle counters on the bus.
module pipe_ctrl_unit #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_ID_W = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter logic [NUM_IRQ-1:0] IRQ_MASK_RESET = '0
) (
  input logic clk,
  input logic reset,
  pipe_ctrl_if.slave bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {NORMAL, DRAIN, ENTER} state_e;
  typedef struct packed {
    logic reg_write, mem_read, mem_write, alu_src1, alu_src2;
    logic [4:0] dst;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_op;
    logic [2:0] branch;
    logic vector, cause;
    logic [IRQ_ID_W-1:0] irq_id;
  } ctrl_t;
  state_e state_q, state_d;
  ctrl_t ex_q, ex_d, dec, vec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] mask_q, pend_q, pend_d, clr;
  logic [IRQ_ID_W-1:0] low;
  logic r_type, link, uses_rt, illegal, jump, lu, irq_go, enter, exc, stall, flush;
  always_comb begin
    r_type = bus.opcode == 6'h00;
    link = bus.opcode == 6'h03 || (bus.opcode == 6'h01 && bus.rt inside {5'd16, 5'd17}) || (r_type && bus.funct == 6'h09);
    uses_rt = r_type || bus.opcode inside {6'h04, 6'h05, 6'h2b};
    illegal = bus.id_valid && !(bus.opcode inside {[6'h00:6'h0c], 6'h0f, 6'h23, 6'h2b});
    jump = bus.id_valid && (bus.opcode inside {6'h02, 6'h03} || (r_type && bus.funct inside {6'h08, 6'h09}));
    lu = bus.id_valid && ex_q.mem_read && ex_q.dst != 5'd0 && (ex_q.dst == bus.rs || (uses_rt && ex_q.dst == bus.rt));
    dec = '0;
    dec.reg_write = (r_type && bus.funct != 6'h08) || bus.opcode inside {[6'h08:6'h0c], 6'h0f, 6'h23} || link;
    dec.dst = !dec.reg_write ? 5'd0 : r_type ? bus.rd : link ? 5'd31 : bus.rt;
    dec.mem_read = bus.opcode == 6'h23;
    dec.mem_write = bus.opcode == 6'h2b;
    dec.alu_src1 = r_type && bus.funct inside {6'h00, 6'h02, 6'h03};
    dec.alu_src2 = bus.opcode inside {[6'h08:6'h0c], 6'h0f, 6'h23, 6'h2b};
    dec.mem_to_reg = link ? 2'b10 : dec.mem_read ? 2'b01 : 2'b00;
    dec.alu_op = {bus.opcode[0], r_type ? 3'b010 : bus.opcode == 6'h04 ? 3'b001 : bus.opcode == 6'h0c ? 3'b100 :
                  bus.opcode inside {6'h0a, 6'h0b} ? 3'b101 : 3'b000};
    dec.branch = bus.opcode inside {[6'h04:6'h07]} ? bus.opcode[2:0] - 3'd3 :
                 bus.opcode == 6'h01 ? (bus.rt[0] ? 3'b110 : 3'b101) : 3'b000;
    low = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) low = pend_q[i] ? IRQ_ID_W'(i) : low;
    irq_go = (|(pend_q & mask_q)) && !bus.kernel_mode && !bus.branch_taken && !illegal && !lu && !jump;
    exc = state_q == NORMAL && illegal && !bus.branch_taken;
    // The ENTER bundle is loaded on the edge into ENTER so ex_vector is visible during ENTER itself
    enter = exc || (state_q == NORMAL && irq_go && DRAIN_CYCLES <= 1) || (state_q == DRAIN && cnt_q <= CW'(1));
    state_d = enter ? ENTER : ((state_q == NORMAL && irq_go) || state_q == DRAIN) ? DRAIN : NORMAL;
    cnt_d = state_q == DRAIN ? cnt_q - CW'(1) : CW'(DRAIN_CYCLES - 1);
    stall = state_q == DRAIN || (state_q == NORMAL && !bus.branch_taken && !illegal && (lu || irq_go));
    flush = state_q == ENTER || bus.branch_taken || (state_q == NORMAL && jump && !lu);
    vec = '0;
    vec.reg_write = 1'b1;
    vec.dst = 5'd26;
    vec.mem_to_reg = 2'b10;
    vec.vector = 1'b1;
    vec.cause = exc;
    vec.irq_id = exc ? '0 : low;
    clr = (enter && !exc) ? NUM_IRQ'(1) << low : '0;
    pend_d = (pend_q | (bus.irq_req & mask_q)) & ~clr;
    ex_d = enter ? vec : (state_q != NORMAL || bus.branch_taken || stall || !bus.id_valid || illegal) ? '0 : dec;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      cnt_q <= '0;
      ex_q <= '0;
      pend_q <= '0;
      mask_q <= IRQ_MASK_RESET;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ex_q <= ex_d;
      pend_q <= pend_d;
      mask_q <= bus.irq_mask_we ? bus.irq_mask_wdata : mask_q;
    end
  end
  assign bus.stall_if = stall;
  assign bus.flush_if_id = flush;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_alu_src1 = ex_q.alu_src1;
  assign bus.ex_alu_src2 = ex_q.alu_src2;
  assign bus.ex_reg_dst_addr = ex_q.dst;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_alu_op = ex_q.alu_op;
  assign bus.ex_branch = ex_q.branch;
  assign bus.ex_vector = ex_q.vector;
  assign bus.ex_cause = ex_q.cause;
  assign bus.irq_id = ex_q.irq_id;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 32'(stall);
      flush_cnt_q <= flush_cnt_q + 32'(flush);
    end
  end
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Registered decode/hazard controller for the 5-stage MIPS pipeline.
- Decodes the instruction in the ID stage into the control bundle and registers it into the ID/EX stage.
- Detects load-use hazards and inserts bubbles; applies branch and jump flushes.
- Arbitrates NUM_IRQ prioritised interrupt channels and illegal-opcode exceptions through an entry state machine.
- Replaces the purely combinational decoder as the single source of all ID/EX control.

Parameters:
NUM_IRQ, 4, number of interrupt request channels (1..8)
IRQ_ID_W, 2, width of irq_id; equals clog2(NUM_IRQ), minimum 1
DRAIN_CYCLES, 3, bubble cycles inserted before interrupt entry so in-flight instructions retire
IRQ_MASK_RESET, {NUM_IRQ{1'b0}}, reset value of the interrupt mask

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a valid instruction
opcode  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
rs  in  5  instruction[25:21]
rt  in  5  instruction[20:16]
rd  in  5  instruction[15:11]
branch_taken  in  1  EX-stage branch resolved taken
kernel_mode  in  1  PC[31]=1; interrupts deferred while high
irq_req  in  NUM_IRQ  level interrupt requests
irq_mask_we  in  1  write strobe for the interrupt mask
irq_mask_wdata  in  NUM_IRQ  new mask value (1 = enabled)
stall_if  out  1  hold PC and IF/ID (combinational)
flush_if_id  out  1  clear IF/ID (combinational)
ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src1, ex_alu_src2  out  1 each  registered control
ex_reg_dst_addr  out  5  registered write register (0 when no write)
ex_mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4
ex_alu_op  out  4  ALU operation code
ex_branch  out  3  branch type (001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez)
ex_vector  out  1  one-cycle pulse: redirect PC to exception vector
ex_cause  out  1  0 interrupt, 1 illegal opcode (valid with ex_vector)
irq_id  out  IRQ_ID_W  channel being serviced (valid with ex_vector)

Behaviour:
- Reset: every ex_* output, irq_id, pending bits and counters go to 0; mask loads IRQ_MASK_RESET; FSM enters NORMAL.
- Legal opcodes: 00, 01, 02-0c, 0f, 23, 2b. Any other opcode with id_valid is illegal.
- Decode:
  - R-type: write rd; jr does not write; jalr writes rd with PC+4.
  - I-type ALU ops and lw: write rt.
  - jal and regimm-with-link (rt = 16 or 17): write $31 with PC+4.
  - sw, branches, j, jr, bltz/bgez: no write.
  - alu_src1 = 1 for sll/srl/sra.
  - alu_src2 = 1 for lw, sw, lui, addi(u), slti(u), andi.
  - alu_op[2:0]: R=010, beq=001, andi=100, slti(u)=101, else 000; alu_op[3] = opcode[0].
- ID/EX register updates every cycle. Priority: reset > ENTER > flush > stall > normal load.
- Bubble: all ex_* outputs 0.
- Load-use: when ex_mem_read=1, ex_reg_dst_addr≠0, and it equals rs, or equals rt for R-type/beq/bne/sw:
  - stall_if=1;
  - bubble loaded into ID/EX;
  - IF/ID held.
- flush_if_id=1 when branch_taken, or when ID decodes j/jal/jr/jalr with id_valid and no stall.
  - branch_taken also forces a bubble into ID/EX.
  - branch_taken wins over a simultaneous stall.
- Interrupt pending:
  - pending[i] sets on irq_req[i] & mask[i];
  - pending[i] is sticky until serviced;
  - an irq_mask_we write takes effect the next cycle.
- FSM:
  - NORMAL → DRAIN when (pending & mask)≠0, kernel_mode=0, and no stall or flush this cycle. The counter loads DRAIN_CYCLES-1, stall_if=1, and a bubble is loaded.
  - NORMAL → ENTER directly on an illegal opcode with id_valid, regardless of kernel_mode. The illegal instruction becomes a bubble.
  - DRAIN: stall_if=1, bubbles loaded, counter decrements; at 0 → ENTER.
  - ENTER, one cycle: ex_vector=1, ex_reg_write=1, ex_reg_dst_addr=26, ex_mem_to_reg=10, flush_if_id=1.
  - In ENTER, irq_id = lowest pending index, and that pending bit is cleared. For an exception, ex_cause=1 and irq_id=0. Then → NORMAL.
- An exception in ID while in DRAIN is discarded (IF/ID is flushed at ENTER).
- Reset mid-DRAIN or mid-ENTER returns to NORMAL with pending bits cleared.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds 32-bit outputs stall_cnt and flush_cnt.
  - stall_cnt increments each cycle stall_if=1; flush_cnt increments each cycle flush_if_id=1.
  - Both wrap at 2^32, clear on reset, and hold their value during reset release.
- Undefined: the ports and the counters do not exist.

Test Plan:
- lw $8,0($9) then add $10,$8,$11 → stall_if=1 for exactly 1 cycle, one bubble in ID/EX, then add decodes with ex_reg_dst_addr=10, ex_alu_op=0010.
- beq resolved taken (branch_taken=1) while ID holds lw-dependent add → flush_if_id=1, ID/EX bubble, stall_if=0.
- mask=4'b0101, irq_req=4'b0110 for 1 cycle, kernel_mode=0 → 3 stall cycles, then ex_vector=1, irq_id=2, ex_reg_dst_addr=26, pending[1] never sets.
- Opcode 6'h3f with id_valid=1 → next cycle ex_vector=1, ex_cause=1, no DRAIN.
- irq_req=4'b0001 with kernel_mode=1 for 10 cycles, then 0 → no entry while high; entry occurs after kernel_mode falls (sticky pending).
- Assert reset during DRAIN → all ex_* outputs 0, stall_if=0 next cycle, no ex_vector pulse follows.
